stack_burst_seq: RTL and testbench

//  Upstream sequencer for the CPU hardware stack (128 x 32). Drives the stack's push/pop/d and consumes its registered q.

---
 rtl/stack_pkg.sv | 16 +
 rtl/stack_occ_counter.sv | 50 +++++
 rtl/stack_burst_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_stack_burst_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared sizing and state encoding for the hardware-stack burst sequencer.
package stack_pkg;

  localparam int unsigned DEPTH   = 128;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH  = 2'd1,
    POP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/stack_occ_counter.sv
// Up/down occupancy counter for the hardware stack, saturating at 0 and DEPTH,
// with headroom/availability compares against a requested burst length.
module stack_occ_counter #(
  parameter int unsigned DEPTH = stack_pkg::DEPTH,
  parameter int unsigned N_W   = stack_pkg::REG_AW + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inc,
  input  logic                           dec,
  input  logic [N_W-1:0]                 req_n,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           room_ok,
  output logic                           avail_ok
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = ((CW > N_W) ? CW : N_W) + 1;

  logic [SW-1:0] cnt_w;
  logic [SW-1:0] n_w;
  logic [SW-1:0] sum_w;
  logic [SW-1:0] depth_w;

  // Headroom compares are done one bit wider so count+N cannot wrap.
  always_comb begin
    cnt_w    = SW'(count);
    n_w      = SW'(req_n);
    sum_w    = cnt_w + n_w;
    depth_w  = SW'(DEPTH);
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    room_ok  = (sum_w <= depth_w);
    avail_ok = (n_w <= cnt_w);
  end

  // Occupancy register; requests past either bound are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/stack_burst_seq.sv
// Sequencer in front of the CPU hardware stack: turns register-range
// save/restore requests into back-to-back push/pop bursts, forwards single
// CPU ops when idle, and blocks/flags overflow, underflow and conflicts.
module stack_burst_seq #(
  parameter int unsigned DEPTH  = stack_pkg::DEPTH,
  parameter int unsigned DATA_W = stack_pkg::DATA_W,
  parameter int unsigned REG_AW = stack_pkg::REG_AW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       dir,
  input  logic [REG_AW-1:0]          first_reg,
  input  logic [REG_AW-1:0]          last_reg,
  input  logic                       hold,
  input  logic                       cpu_push,
  input  logic                       cpu_pop,
  input  logic [DATA_W-1:0]          cpu_d,
  output logic                       busy,
  output logic                       done,
  output logic [REG_AW-1:0]          rf_raddr,
  input  logic [DATA_W-1:0]          rf_rdata,
  output logic                       rf_we,
  output logic [REG_AW-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       stack_push,
  output logic                       stack_pop,
  output logic [DATA_W-1:0]          stack_d,
  input  logic [DATA_W-1:0]          stack_q,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic                       err_conf,
  output logic                       err_irq
);

  import stack_pkg::*;

  state_t              state_q, state_d;
  logic [REG_AW-1:0]   ptr_q, ptr_d;
  logic [REG_AW-1:0]   end_q, end_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic                pend_q, pend_d;
  logic                bufv_q, bufv_d;
  logic                pop_q, pop_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  logic [REG_AW:0]     n_len;
  logic                full, empty, room_ok, avail_ok;
  logic                range_ok, accept, cpu_any;
  logic                finish_pend, capture;

  stack_occ_counter #(
    .DEPTH (DEPTH),
    .N_W   (REG_AW + 1)
  ) u_occ (
    .clk      (clk),
    .reset    (reset),
    .inc      (stack_push),
    .dec      (stack_pop),
    .req_n    (n_len),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .room_ok  (room_ok),
    .avail_ok (avail_ok)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      waddr_q <= '0;
      pend_q  <= 1'b0;
      bufv_q  <= 1'b0;
      pop_q   <= 1'b0;
      done_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      waddr_q <= waddr_d;
      pend_q  <= pend_d;
      bufv_q  <= bufv_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state, burst issue, single-op forwarding and error pulses.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    waddr_d     = waddr_q;
    pend_d      = pend_q;
    bufv_d      = bufv_q;
    pop_d       = pop_q;
    done_d      = 1'b0;
    buf_d       = buf_q;

    busy        = (state_q != IDLE);
    done        = done_q;
    rf_raddr    = ptr_q;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    stack_d     = '0;
    err_ovf     = 1'b0;
    err_unf     = 1'b0;
    err_conf    = 1'b0;

    n_len       = {1'b0, last_reg} - {1'b0, first_reg} + (REG_AW + 1)'(1);
    range_ok    = (first_reg <= last_reg);
    cpu_any     = cpu_push | cpu_pop;
    accept      = 1'b0;
    finish_pend = 1'b0;
    capture     = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold) begin
          err_conf = cpu_any;
        end else begin
          if (start) begin
            if (!range_ok)               err_conf = 1'b1;
            else if (!dir && !room_ok)   err_ovf  = 1'b1;
            else if (dir && !avail_ok)   err_unf  = 1'b1;
            else                         accept   = 1'b1;
          end
          if (accept) begin
            state_d  = dir ? POP : PUSH;
            ptr_d    = dir ? last_reg : first_reg;
            end_d    = dir ? first_reg : last_reg;
            pop_d    = dir;
            pend_d   = 1'b0;
            bufv_d   = 1'b0;
            err_conf = err_conf | cpu_any;
          end else if (cpu_push && cpu_pop) begin
            err_conf = 1'b1;
          end else if (cpu_push) begin
            if (full) begin
              err_ovf = 1'b1;
            end else begin
              stack_push = 1'b1;
              stack_d    = cpu_d;
            end
          end else if (cpu_pop) begin
            if (empty) err_unf   = 1'b1;
            else       stack_pop = 1'b1;
          end
        end
      end
      PUSH, POP: begin
        err_conf = cpu_any;
        if (hold) begin
          capture = 1'b1;
        end else begin
          finish_pend = 1'b1;
          stack_pop   = pop_q;
          waddr_d     = ptr_q;
          pend_d      = 1'b1;
          bufv_d      = 1'b0;
          if (ptr_q == end_q) state_d = DRAIN;
          else                ptr_d   = pop_q ? ptr_q - REG_AW'(1) : ptr_q + REG_AW'(1);
        end
      end
      DRAIN: begin
        err_conf = cpu_any;
        if (hold) begin
          capture = 1'b1;
        end else begin
          finish_pend = 1'b1;
          pend_d      = 1'b0;
          bufv_d      = 1'b0;
          state_d     = IDLE;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The read/pop issued in the previous active cycle completes here; if a
    // stall lands on that cycle the live word is parked in buf_q instead.
    if (finish_pend && pend_q) begin
      if (pop_q) begin
        rf_we    = 1'b1;
        rf_waddr = waddr_q;
        rf_wdata = bufv_q ? buf_q : stack_q;
      end else begin
        stack_push = 1'b1;
        stack_d    = bufv_q ? buf_q : rf_rdata;
      end
    end
    if (capture && pend_q && !bufv_q) begin
      buf_d  = pop_q ? stack_q : rf_rdata;
      bufv_d = 1'b1;
    end

    err_irq = err_ovf | err_unf | err_conf;

    if (reset) begin
      busy       = 1'b0;
      done       = 1'b0;
      rf_raddr   = '0;
      rf_we      = 1'b0;
      rf_waddr   = '0;
      rf_wdata   = '0;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      stack_d    = '0;
      err_ovf    = 1'b0;
      err_unf    = 1'b0;
      err_conf   = 1'b0;
      err_irq    = 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_burst_seq.sv
// Directed bench for stack_burst_seq with behavioural register file and stack.
module tb_stack_burst_seq;

  localparam int DEPTH  = 128;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  logic              clk = 1'b0;
  logic              reset, start, dir, hold, cpu_push, cpu_pop;
  logic [3:0]        first_reg, last_reg;
  logic [31:0]       cpu_d;
  logic              busy, done, rf_we, stack_push, stack_pop;
  logic [3:0]        rf_raddr, rf_waddr;
  logic [31:0]       rf_rdata, rf_wdata, stack_d, stack_q;
  logic [7:0]        count;
  logic              err_ovf, err_unf, err_conf, err_irq;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // Register file: synchronous read, reloadable with 0x100+addr.
  logic [31:0] rf [16];
  logic        rf_init;
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'h100 + i;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
    rf_rdata <= rf[rf_raddr];
  end

  // Stack: registered q valid the cycle after a pop; shares reset.
  logic [31:0] smem [DEPTH];
  int          sp;
  always @(posedge clk) begin
    if (reset) begin
      sp      <= 0;
      stack_q <= '0;
    end else if (stack_push && sp < DEPTH) begin
      smem[sp] <= stack_d;
      sp       <= sp + 1;
    end else if (stack_pop && sp > 0) begin
      stack_q <= smem[sp-1];
      sp      <= sp - 1;
    end
  end

  stack_burst_seq #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dir        (dir),
    .first_reg  (first_reg),
    .last_reg   (last_reg),
    .hold       (hold),
    .cpu_push   (cpu_push),
    .cpu_pop    (cpu_pop),
    .cpu_d      (cpu_d),
    .busy       (busy),
    .done       (done),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stack_push (stack_push),
    .stack_pop  (stack_pop),
    .stack_d    (stack_d),
    .stack_q    (stack_q),
    .count      (count),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf),
    .err_conf   (err_conf),
    .err_irq    (err_irq)
  );

  // Stimulus helper: issue one burst and wait (bounded) for done.
  task run_burst(input logic d, input logic [3:0] f, input logic [3:0] l);
    int  n;
    bit  got;
    start = 1'b1; dir = d; first_reg = f; last_reg = l;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
      n++;
    end
    vecs++;
    if (!got) begin errs++; $display("FAIL burst_done_timeout got=no_done exp=done"); end
    @(posedge clk); #1;
  endtask

  task reload_rf();
    rf_init = 1'b1;
    @(posedge clk); #1;
    rf_init = 1'b0;
  endtask

  task test_reset();
    reset = 1'b1; start = 0; dir = 0; hold = 0; cpu_push = 0; cpu_pop = 0;
    first_reg = '0; last_reg = '0; cpu_d = '0; rf_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    vecs++; if (count !== 8'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%0b exp=0", done); end
    vecs++; if ({stack_push, stack_pop, rf_we, err_irq} !== 4'b0)
      begin errs++; $display("FAIL reset_strobes got=%b exp=0000", {stack_push, stack_pop, rf_we, err_irq}); end
    @(posedge clk); #1;
    reset = 1'b0; rf_init = 1'b0;
    @(negedge clk);
    vecs++; if (count !== 8'd0 || busy !== 1'b0) begin errs++; $display("FAIL post_reset got=%0d/%0b exp=0/0", count, busy); end
    @(posedge clk); #1;
  endtask

  // Push r1..r15 from empty: reads T+1..T+15, pushes T+2..T+16, done T+17.
  task test_push_burst();
    logic e_busy, e_push, e_done;
    logic [31:0] e_d;
    start = 1'b1; dir = 1'b0; first_reg = 4'd1; last_reg = 4'd15;
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || err_irq !== 1'b0) begin errs++; $display("FAIL push_accept got=%0b/%0b exp=0/0", busy, err_irq); end
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      e_busy = (k >= 1 && k <= 16);
      e_push = (k >= 2 && k <= 16);
      e_done = (k == 17);
      e_d    = 32'h100 + 32'(k - 1);
      vecs++; if (busy !== e_busy) begin errs++; $display("FAIL push_busy k=%0d got=%0b exp=%0b", k, busy, e_busy); end
      vecs++; if (stack_push !== e_push) begin errs++; $display("FAIL push_strobe k=%0d got=%0b exp=%0b", k, stack_push, e_push); end
      vecs++; if (done !== e_done) begin errs++; $display("FAIL push_done k=%0d got=%0b exp=%0b", k, done, e_done); end
      if (k <= 15) begin
        vecs++; if (rf_raddr !== 4'(k)) begin errs++; $display("FAIL push_raddr k=%0d got=%0d exp=%0d", k, rf_raddr, k); end
      end
      if (e_push) begin
        vecs++; if (stack_d !== e_d) begin errs++; $display("FAIL push_data k=%0d got=%h exp=%h", k, stack_d, e_d); end
      end
    end
    vecs++; if (count !== 8'd15) begin errs++; $display("FAIL push_count got=%0d exp=15", count); end
    @(posedge clk); #1;
  endtask

  // Pop r1..r15: pops T+1..T+15, writes r15..r1 at T+2..T+16, done T+17.
  task test_pop_burst();
    logic e_pop, e_we, e_done;
    logic [3:0] e_a;
    start = 1'b1; dir = 1'b1; first_reg = 4'd1; last_reg = 4'd15;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      e_pop  = (k <= 15);
      e_we   = (k >= 2 && k <= 16);
      e_done = (k == 17);
      e_a    = 4'(17 - k);
      vecs++; if (stack_pop !== e_pop) begin errs++; $display("FAIL pop_strobe k=%0d got=%0b exp=%0b", k, stack_pop, e_pop); end
      vecs++; if (rf_we !== e_we) begin errs++; $display("FAIL pop_we k=%0d got=%0b exp=%0b", k, rf_we, e_we); end
      vecs++; if (done !== e_done) begin errs++; $display("FAIL pop_done k=%0d got=%0b exp=%0b", k, done, e_done); end
      if (e_we) begin
        vecs++; if (rf_waddr !== e_a) begin errs++; $display("FAIL pop_waddr k=%0d got=%0d exp=%0d", k, rf_waddr, e_a); end
        vecs++; if (rf_wdata !== 32'h100 + 32'(e_a)) begin errs++; $display("FAIL pop_wdata k=%0d got=%h exp=%h", k, rf_wdata, 32'h100 + 32'(e_a)); end
      end
    end
    vecs++; if (count !== 8'd0) begin errs++; $display("FAIL pop_count got=%0d exp=0", count); end
    @(posedge clk); #1;
  endtask

  task test_overflow_underflow();
    repeat (8) run_burst(1'b0, 4'd1, 4'd15);
    @(negedge clk);
    vecs++; if (count !== 8'd120) begin errs++; $display("FAIL fill_count got=%0d exp=120", count); end
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b0; first_reg = 4'd0; last_reg = 4'd15;
    @(negedge clk);
    vecs++; if (err_ovf !== 1'b1) begin errs++; $display("FAIL ovf_burst got=%0b exp=1", err_ovf); end
    vecs++; if (err_irq !== 1'b1) begin errs++; $display("FAIL ovf_irq got=%0b exp=1", err_irq); end
    vecs++; if (err_conf !== 1'b0) begin errs++; $display("FAIL ovf_conf got=%0b exp=0", err_conf); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || stack_push !== 1'b0) begin errs++; $display("FAIL ovf_reject got=%0b/%0b exp=0/0", busy, stack_push); end
    vecs++; if (err_ovf !== 1'b0) begin errs++; $display("FAIL ovf_pulse got=%0b exp=0", err_ovf); end
    vecs++; if (count !== 8'd120) begin errs++; $display("FAIL ovf_count got=%0d exp=120", count); end
    @(posedge clk); #1;
    run_burst(1'b0, 4'd0, 4'd7);
    @(negedge clk);
    vecs++; if (count !== 8'd128) begin errs++; $display("FAIL exact_fill got=%0d exp=128", count); end
    @(posedge clk); #1;
    cpu_push = 1'b1; cpu_d = 32'h1234_5678;
    @(negedge clk);
    vecs++; if (err_ovf !== 1'b1 || stack_push !== 1'b0) begin errs++; $display("FAIL full_single got=%0b/%0b exp=1/0", err_ovf, stack_push); end
    @(posedge clk); #1;
    cpu_push = 1'b0;
    @(negedge clk);
    vecs++; if (count !== 8'd128) begin errs++; $display("FAIL full_count got=%0d exp=128", count); end
    @(posedge clk); #1;
    repeat (8) run_burst(1'b1, 4'd0, 4'd15);
    @(negedge clk);
    vecs++; if (count !== 8'd0) begin errs++; $display("FAIL empty_count got=%0d exp=0", count); end
    @(posedge clk); #1;
    cpu_pop = 1'b1;
    @(negedge clk);
    vecs++; if (err_unf !== 1'b1 || stack_pop !== 1'b0) begin errs++; $display("FAIL empty_single got=%0b/%0b exp=1/0", err_unf, stack_pop); end
    vecs++; if (err_irq !== 1'b1) begin errs++; $display("FAIL unf_irq got=%0b exp=1", err_irq); end
    @(posedge clk); #1;
    cpu_pop = 1'b0;
    start = 1'b1; dir = 1'b1; first_reg = 4'd0; last_reg = 4'd0;
    @(negedge clk);
    vecs++; if (err_unf !== 1'b1 || stack_pop !== 1'b0) begin errs++; $display("FAIL unf_burst got=%0b/%0b exp=1/0", err_unf, stack_pop); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || count !== 8'd0) begin errs++; $display("FAIL unf_reject got=%0b/%0d exp=0/0", busy, count); end
    @(posedge clk); #1;
  endtask

  // Pop r1..r8 with hold over cycles 5..7: everything after pop 4 slips 3 cycles.
  task test_hold();
    logic e_pop, e_we, e_busy;
    logic [3:0] e_a;
    reload_rf();
    run_burst(1'b0, 4'd1, 4'd8);
    start = 1'b1; dir = 1'b1; first_reg = 4'd1; last_reg = 4'd8;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      hold  = (k >= 5 && k <= 7);
      @(negedge clk);
      e_pop  = (k <= 4) || (k >= 8 && k <= 11);
      e_we   = (k >= 2 && k <= 4) || (k >= 8 && k <= 12);
      e_busy = (k <= 12);
      e_a    = (k <= 4) ? 4'(10 - k) : 4'(13 - k);
      vecs++; if (stack_pop !== e_pop) begin errs++; $display("FAIL hold_pop k=%0d got=%0b exp=%0b", k, stack_pop, e_pop); end
      vecs++; if (rf_we !== e_we) begin errs++; $display("FAIL hold_we k=%0d got=%0b exp=%0b", k, rf_we, e_we); end
      vecs++; if (busy !== e_busy) begin errs++; $display("FAIL hold_busy k=%0d got=%0b exp=%0b", k, busy, e_busy); end
      vecs++; if (done !== (k == 13)) begin errs++; $display("FAIL hold_done k=%0d got=%0b exp=%0b", k, done, (k == 13)); end
      if (e_we) begin
        vecs++; if (rf_waddr !== e_a || rf_wdata !== 32'h100 + 32'(e_a))
          begin errs++; $display("FAIL hold_write k=%0d got=%0d:%h exp=%0d:%h", k, rf_waddr, rf_wdata, e_a, 32'h100 + 32'(e_a)); end
      end
    end
    vecs++; if (count !== 8'd0) begin errs++; $display("FAIL hold_count got=%0d exp=0", count); end
    @(posedge clk); #1;
  endtask

  task test_conflicts();
    start = 1'b1; dir = 1'b0; first_reg = 4'd0; last_reg = 4'd1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      cpu_push = (k == 1); cpu_d = 32'hDEAD_BEEF;
      @(negedge clk);
      vecs++; if (err_conf !== (k == 1)) begin errs++; $display("FAIL busy_conf k=%0d got=%0b exp=%0b", k, err_conf, (k == 1)); end
      vecs++; if (stack_push !== (k == 2 || k == 3)) begin errs++; $display("FAIL busy_push k=%0d got=%0b exp=%0b", k, stack_push, (k == 2 || k == 3)); end
      vecs++; if (done !== (k == 4)) begin errs++; $display("FAIL busy_done k=%0d got=%0b exp=%0b", k, done, (k == 4)); end
    end
    vecs++; if (count !== 8'd2) begin errs++; $display("FAIL busy_count got=%0d exp=2", count); end
    @(posedge clk); #1;
    cpu_push = 1'b1; cpu_pop = 1'b1;
    @(negedge clk);
    vecs++; if (err_conf !== 1'b1 || stack_push !== 1'b0 || stack_pop !== 1'b0)
      begin errs++; $display("FAIL both_conf got=%0b/%0b/%0b exp=1/0/0", err_conf, stack_push, stack_pop); end
    @(posedge clk); #1;
    cpu_pop = 1'b0;
    @(negedge clk);
    vecs++; if (stack_push !== 1'b1 || stack_d !== 32'hDEAD_BEEF || err_irq !== 1'b0)
      begin errs++; $display("FAIL single_push got=%0b/%h/%0b exp=1/deadbeef/0", stack_push, stack_d, err_irq); end
    vecs++; if (count !== 8'd2) begin errs++; $display("FAIL both_count got=%0d exp=2", count); end
    @(posedge clk); #1;
    cpu_push = 1'b0;
    start = 1'b1; dir = 1'b0; first_reg = 4'd4; last_reg = 4'd4; cpu_pop = 1'b1;
    @(negedge clk);
    vecs++; if (count !== 8'd3) begin errs++; $display("FAIL single_count got=%0d exp=3", count); end
    vecs++; if (err_conf !== 1'b1 || stack_pop !== 1'b0) begin errs++; $display("FAIL start_wins got=%0b/%0b exp=1/0", err_conf, stack_pop); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0; cpu_pop = 1'b0;
      @(negedge clk);
      vecs++; if (busy !== (k <= 2)) begin errs++; $display("FAIL start_busy k=%0d got=%0b exp=%0b", k, busy, (k <= 2)); end
      vecs++; if (done !== (k == 3)) begin errs++; $display("FAIL start_done k=%0d got=%0b exp=%0b", k, done, (k == 3)); end
    end
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b0; first_reg = 4'd5; last_reg = 4'd3;
    @(negedge clk);
    vecs++; if (err_conf !== 1'b1) begin errs++; $display("FAIL bad_range got=%0b exp=1", err_conf); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || count !== 8'd4) begin errs++; $display("FAIL bad_range_state got=%0b/%0d exp=0/4", busy, count); end
    @(posedge clk); #1;
  endtask

  task test_reset_midburst();
    reload_rf();
    start = 1'b1; dir = 1'b0; first_reg = 4'd0; last_reg = 4'd15;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      reset = (k == 5);
      @(negedge clk);
      if (k >= 6) begin
        vecs++; if (busy !== 1'b0 || done !== 1'b0 || count !== 8'd0)
          begin errs++; $display("FAIL abort k=%0d got=%0b/%0b/%0d exp=0/0/0", k, busy, done, count); end
      end
    end
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b0; first_reg = 4'd2; last_reg = 4'd3;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      vecs++; if (stack_push !== (k == 2 || k == 3)) begin errs++; $display("FAIL rerun_push k=%0d got=%0b exp=%0b", k, stack_push, (k == 2 || k == 3)); end
      if (k == 2 || k == 3) begin
        vecs++; if (stack_d !== 32'h100 + 32'(k)) begin errs++; $display("FAIL rerun_data k=%0d got=%h exp=%h", k, stack_d, 32'h100 + 32'(k)); end
      end
      vecs++; if (done !== (k == 4)) begin errs++; $display("FAIL rerun_done k=%0d got=%0b exp=%0b", k, done, (k == 4)); end
    end
    vecs++; if (count !== 8'd2) begin errs++; $display("FAIL rerun_count got=%0d exp=2", count); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_push_burst();
    test_pop_burst();
    test_overflow_underflow();
    test_hold();
    test_conflicts();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
